i2c_slave: RTL
==============

# i2c_slave

Responder end of the team's I2C link: a single-address I2C target that answers the existing `master` block over the same `sclk` / `sda_in` / `sda_out` wiring. It runs on the system clock and oversamples the bus. It detects START/STOP, matches a 7-bit address and ACKs it, then either receives bytes for the host logic (master write) or transmits bytes supplied by the host logic (master read). It sits opposite `master` in loop-back benches and in the SoC peripheral slot.

## Interface
- `ADDR`, default 7'h42: own 7-bit slave address.
- `clk  in  1`: system clock; all logic on rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `sclk  in  1`: bus clock from the master; asynchronous to `clk`.
- `sda_in  in  1`: bus data as seen on the wire.
- `sda_out  out  1`: open-drain intent; 0 = pull low, 1 = release.
- `data_in  in  8`: byte to transmit on a master read; sampled when `data_req` pulses.
- `data_req  out  1`: one-`clk` pulse requesting/latching the next `data_in`.
- `data_out  out  8`: last received byte.
- `data_valid  out  1`: one-`clk` pulse when `data_out` updates.
- `state  out  3`: current FSM state, for debug and benches.

## Operation
- `sclk` and `sda_in` pass through 2-flop synchronizers, then a third register for edge detection.
- START: synchronized SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Data bits are sampled on the detected SCL rise. `sda_out` changes only on the detected SCL fall.
- All transfers are MSB first. A 4-bit bit counter runs 0..8, and bit 8 is the ACK slot.
- States: IDLE=0, ADDRESS=1, ACK_ADDR=2, TX=3, RX=4, ACK_RX=5, MACK=6.
- IDLE: `sda_out` is released. START → ADDRESS with the counter cleared.
- ADDRESS: shift in 8 bits (7 address bits, then the R/W bit).
  - Match → ACK_ADDR.
  - Mismatch → IDLE without ACK; the slave ignores the bus until the next START.
- ACK_ADDR: drive 0 for the 9th SCL period.
  - On the ending SCL fall with R/W=1: pulse `data_req`, latch `data_in` into the shift register, drive its MSB, go to TX.
  - On the ending SCL fall with R/W=0: go to RX.
- TX: shift the next bit out on each SCL fall. After 8 bits, release SDA and go to MACK.
- MACK: sample SDA on the SCL rise.
  - 0 (ACK) → on the SCL fall pulse `data_req`, reload, go to TX.
  - 1 (NACK) → IDLE.
- RX: sample 8 bits. On the 8th SCL rise, update `data_out`, pulse `data_valid`, go to ACK_RX.
- ACK_RX: drive 0 for the 9th SCL period, then return to RX on the SCL fall.
- START in any non-IDLE state (repeated start) → ADDRESS. The current byte is abandoned with no `data_valid`.
- STOP in any state → IDLE, with `sda_out` released in the same cycle.

## Timing
- Reset values: `sda_out`=1, `data_out`=8'h00, `data_valid`=0, `data_req`=0, `state`=IDLE. Synchronizer flops reset to 1 (idle bus).
- Bus-to-detect latency is 3 `clk` from the pin change to the edge/START/STOP strobe.
- `sda_out` changes 1 `clk` after the detected SCL fall, well inside the SCL low phase.
- `sclk` high and low phases must each be ≥ 6 `clk`. Shorter phases are out of spec and behaviour is undefined.
- `data_valid` is asserted in the `clk` after the 8th detected SCL rise.
- `data_in` must be stable in the cycle `data_req` is high.
- A START and an SCL edge never coincide on a legal bus. If both strobes occur in one cycle, START/STOP wins.
- Reset mid-transfer: immediate return to reset values with SDA released. The slave is then deaf until a new START.

## Structure
- The shared package `i2c_pkg` holds:
  - the SLAVE_STATE_* encodings, alongside the existing MASTER_STATE_* ones;
  - the ACK=0 / NACK=1 constants;
  - the READ=1 / WRITE=0 constants.
- Sub-module `i2c_sync_edge` contains one 2-flop synchronizer plus edge register and outputs `level`, `rise`, `fall`. It is instantiated twice, once for SCL and once for SDA.

## Test plan
- Write: START, address 0x42+W, byte 0xA5, STOP.
  - ACK low in both 9th periods.
  - `data_out`=0xA5 with one `data_valid` pulse.
  - `state` ends in IDLE.
- Read: START, 0x42+R, `data_in`=0xF6, master NACK.
  - SDA carries 1,1,1,1,0,1,1,0.
  - Exactly one `data_req` pulse.
  - IDLE after the NACK.
- Multi-byte read: `data_in` 0x12 then 0x34, master ACKs the first byte and NACKs the second.
  - Two `data_req` pulses; SDA shows both bytes.
- Address mismatch: START, 0x43+W, byte 0xFF.
  - SDA never driven low.
  - No `data_valid`; stays IDLE after the address byte.
- Repeated START after 4 bits of a write byte, then 0x42+R.
  - No `data_valid`; ACK driven; enters TX.
- STOP mid-byte, and `rst` low mid-TX.
  - `sda_out`=1 next cycle, `state`=IDLE.
  - A following proper write still receives correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C encodings for the master and slave ends of the link.
// Bus-level constants plus the debug-visible FSM state codes.
package i2c_pkg;

  localparam logic [2:0] MASTER_STATE_IDLE     = 3'd0;
  localparam logic [2:0] MASTER_STATE_START    = 3'd1;
  localparam logic [2:0] MASTER_STATE_ADDR     = 3'd2;
  localparam logic [2:0] MASTER_STATE_ACK_ADDR = 3'd3;
  localparam logic [2:0] MASTER_STATE_WRITE    = 3'd4;
  localparam logic [2:0] MASTER_STATE_READ     = 3'd5;
  localparam logic [2:0] MASTER_STATE_ACK      = 3'd6;
  localparam logic [2:0] MASTER_STATE_STOP     = 3'd7;

  typedef enum logic [2:0] {
    SLAVE_STATE_IDLE     = 3'd0,
    SLAVE_STATE_ADDRESS  = 3'd1,
    SLAVE_STATE_ACK_ADDR = 3'd2,
    SLAVE_STATE_TX       = 3'd3,
    SLAVE_STATE_RX       = 3'd4,
    SLAVE_STATE_ACK_RX   = 3'd5,
    SLAVE_STATE_MACK     = 3'd6
  } slave_state_t;

  localparam logic ACK   = 1'b0;
  localparam logic NACK  = 1'b1;
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus edge register for one bus line; strobes are valid
// two clk after the pin change and sampled by the consumer on the third.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  // Resets high so an idle (pulled-up) bus produces no spurious edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr <= 3'b111;
    else      sr <= {sr[1:0], din};
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target: oversamples SCL/SDA, ACKs its address, receives or transmits bytes.
// sda_out moves 1 clk after a detected SCL fall; data_req is combinational with the data_in latch.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] data_in,
  output logic       data_req,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [2:0] state
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk   (clk),
    .rst   (rst),
    .din   (sda_in),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  slave_state_t state_q, state_n;
  logic [3:0]   cnt_q, cnt_n;
  logic [7:0]   sh_q, sh_n, sh_in;
  logic [7:0]   dout_q, dout_n;
  logic         rw_q, rw_n;
  logic         mack_q, mack_n;
  logic         sda_q, sda_n;
  logic         dvld_q, dvld_n;
  logic         req;

  assign sh_in = {sh_q[6:0], sda_lvl};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SLAVE_STATE_IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 8'h00;
      dout_q  <= 8'h00;
      rw_q    <= WRITE;
      mack_q  <= NACK;
      sda_q   <= 1'b1;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sh_q    <= sh_n;
      dout_q  <= dout_n;
      rw_q    <= rw_n;
      mack_q  <= mack_n;
      sda_q   <= sda_n;
      dvld_q  <= dvld_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sh_n    = sh_q;
    dout_n  = dout_q;
    rw_n    = rw_q;
    mack_n  = mack_q;
    sda_n   = sda_q;
    dvld_n  = 1'b0;
    req     = 1'b0;

    if (stop_det) begin
      state_n = SLAVE_STATE_IDLE;
      sda_n   = 1'b1;
    end else if (start_det) begin
      state_n = SLAVE_STATE_ADDRESS;
      cnt_n   = 4'd0;
      sda_n   = 1'b1;
    end else begin
      case (state_q)
        SLAVE_STATE_IDLE: sda_n = 1'b1;

        SLAVE_STATE_ADDRESS: if (scl_rise) begin
          sh_n  = sh_in;
          cnt_n = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            rw_n    = sh_in[0];
            state_n = (sh_in[7:1] == ADDR) ? SLAVE_STATE_ACK_ADDR : SLAVE_STATE_IDLE;
          end
        end

        // sda_q doubles as the marker: released means the ACK period is just starting.
        SLAVE_STATE_ACK_ADDR: if (scl_fall) begin
          if (sda_q) begin
            sda_n = ACK;
          end else if (rw_q == READ) begin
            req     = 1'b1;
            sh_n    = data_in;
            sda_n   = data_in[7];
            cnt_n   = 4'd0;
            state_n = SLAVE_STATE_TX;
          end else begin
            sda_n   = 1'b1;
            cnt_n   = 4'd0;
            state_n = SLAVE_STATE_RX;
          end
        end

        SLAVE_STATE_TX: if (scl_fall) begin
          if (cnt_q == 4'd7) begin
            sda_n   = 1'b1;
            cnt_n   = 4'd8;
            mack_n  = NACK;
            state_n = SLAVE_STATE_MACK;
          end else begin
            sh_n  = {sh_q[6:0], 1'b0};
            sda_n = sh_q[6];
            cnt_n = cnt_q + 4'd1;
          end
        end

        SLAVE_STATE_MACK: begin
          if (scl_rise) begin
            mack_n = sda_lvl;
            if (sda_lvl == NACK) state_n = SLAVE_STATE_IDLE;
          end else if (scl_fall && mack_q == ACK) begin
            req     = 1'b1;
            sh_n    = data_in;
            sda_n   = data_in[7];
            cnt_n   = 4'd0;
            state_n = SLAVE_STATE_TX;
          end
        end

        SLAVE_STATE_RX: if (scl_rise) begin
          sh_n  = sh_in;
          cnt_n = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            dout_n  = sh_in;
            dvld_n  = 1'b1;
            state_n = SLAVE_STATE_ACK_RX;
          end
        end

        SLAVE_STATE_ACK_RX: if (scl_fall) begin
          if (sda_q) begin
            sda_n = ACK;
          end else begin
            sda_n   = 1'b1;
            cnt_n   = 4'd0;
            state_n = SLAVE_STATE_RX;
          end
        end

        default: begin
          state_n = SLAVE_STATE_IDLE;
          sda_n   = 1'b1;
        end
      endcase
    end
  end

  assign sda_out    = sda_q;
  assign data_req   = req;
  assign data_out   = dout_q;
  assign data_valid = dvld_q;
  assign state      = state_q;

endmodule
